// File: rtl/pll_seq_pkg.sv
// Shared state encoding, field widths and default timing constants for the PLL reset sequencer.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      ST_ARESET    = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAIL      = 3'd5
   } state_e;

   localparam int unsigned DEF_NUM_DOMAINS   = 4;
   localparam int unsigned DEF_ARESET_CYCLES = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT  = 1048576;
   localparam int unsigned DEF_LOCK_STABLE   = 1024;
   localparam int unsigned DEF_STAGGER       = 256;
   localparam int unsigned DEF_MAX_RETRY     = 3;

   localparam int unsigned RETRY_W = 2;
   localparam int unsigned LOSS_W  = 8;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL bring-up sequencer: pulses PLL reset, waits for a stable lock, then releases
// downstream domain resets one by one; retries on timeout and resequences on lock loss.
module pll_reset_seq
   import pll_seq_pkg::*;
#(
   parameter int unsigned NUM_DOMAINS   = DEF_NUM_DOMAINS,
   parameter int unsigned ARESET_CYCLES = DEF_ARESET_CYCLES,
   parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int unsigned LOCK_STABLE   = DEF_LOCK_STABLE,
   parameter int unsigned STAGGER       = DEF_STAGGER,
   parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pll_locked,
   input  logic                   soft_rst_req,
   input  logic                   retry_req,
   output logic                   pll_areset,
   output logic [NUM_DOMAINS-1:0] rst_out,
   output logic                   ready,
   output logic                   fail,
   output logic [1:0]             retry_cnt,
   output logic [7:0]             loss_cnt
);

   localparam int unsigned REL_LAST = (NUM_DOMAINS - 1) * STAGGER;
   localparam int unsigned CNT_MAX  = max2(max2(ARESET_CYCLES, LOCK_TIMEOUT),
                                           max2(LOCK_STABLE, REL_LAST + 1));
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   pll_areset_q, pll_areset_d;
   logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
   logic                   ready_q, ready_d;
   logic                   fail_q, fail_d;
   logic [RETRY_W-1:0]     retry_cnt_q, retry_cnt_d;
   logic [LOSS_W-1:0]      loss_cnt_q, loss_cnt_d;
   logic                   locked_s;
   logic                   enter_c;
   logic                   retry_ok_c;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pll_locked),
      .q     (locked_s)
   );

   // Next state, shared counter and registered-output values
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CNT_W'(1);
      enter_c     = 1'b0;
      retry_cnt_d = retry_cnt_q;
      loss_cnt_d  = loss_cnt_q;
      retry_ok_c  = (retry_cnt_q < RETRY_W'(MAX_RETRY));

      case (state_q)
         ST_ARESET: begin
            if (cnt_q == CNT_W'(ARESET_CYCLES - 1)) begin
               state_d = ST_WAIT_LOCK;
               enter_c = 1'b1;
            end
         end
         ST_WAIT_LOCK: begin
            if (locked_s) begin
               state_d = ST_STABLE;
               enter_c = 1'b1;
            end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
               enter_c = 1'b1;
               if (retry_ok_c) begin
                  retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                  state_d     = ST_ARESET;
               end else begin
                  state_d = ST_FAIL;
               end
            end
         end
         ST_STABLE: begin
            if (!locked_s) begin
               state_d = ST_WAIT_LOCK;
               enter_c = 1'b1;
            end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
               state_d = ST_RELEASE;
               enter_c = 1'b1;
            end
         end
         ST_RELEASE: begin
            if (!locked_s) begin
               enter_c = 1'b1;
               if (retry_ok_c) begin
                  retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                  state_d     = ST_ARESET;
               end else begin
                  state_d = ST_FAIL;
               end
            end else if (cnt_q == CNT_W'(REL_LAST)) begin
               state_d = ST_RUN;
               enter_c = 1'b1;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q;
            if (!locked_s) begin
               state_d = ST_ARESET;
               enter_c = 1'b1;
               if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + LOSS_W'(1);
            end
         end
         ST_FAIL: begin
            cnt_d = cnt_q;
            if (retry_req) begin
               retry_cnt_d = '0;
               state_d     = ST_ARESET;
               enter_c     = 1'b1;
            end
         end
         default: begin
            state_d = ST_ARESET;
            enter_c = 1'b1;
         end
      endcase

      // Software restart overrides any lock or timeout event this cycle
      if (soft_rst_req && (state_q != ST_FAIL)) begin
         state_d     = ST_ARESET;
         enter_c     = 1'b1;
         retry_cnt_d = '0;
         loss_cnt_d  = loss_cnt_q;
      end

      if (state_d == ST_RUN) retry_cnt_d = '0;
      if (enter_c)           cnt_d       = '0;

      pll_areset_d = (state_d == ST_ARESET) || (state_d == ST_FAIL);
      fail_d       = (state_d == ST_FAIL);
      ready_d      = (state_d == ST_RUN);
      rst_out_d    = '1;
      if (state_d == ST_RUN) begin
         rst_out_d = '0;
      end else if (state_d == ST_RELEASE) begin
         // Domain i stays in reset until i*STAGGER cycles after RELEASE entry
         for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
            rst_out_d[i] = (32'(cnt_d) < 32'(i * STAGGER));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_ARESET;
         cnt_q        <= '0;
         pll_areset_q <= 1'b1;
         rst_out_q    <= '1;
         ready_q      <= 1'b0;
         fail_q       <= 1'b0;
         retry_cnt_q  <= '0;
         loss_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pll_areset_q <= pll_areset_d;
         rst_out_q    <= rst_out_d;
         ready_q      <= ready_d;
         fail_q       <= fail_d;
         retry_cnt_q  <= retry_cnt_d;
         loss_cnt_q   <= loss_cnt_d;
      end
   end

   assign pll_areset = pll_areset_q;
   assign rst_out    = rst_out_q;
   assign ready      = ready_q;
   assign fail       = fail_q;
   assign retry_cnt  = retry_cnt_q;
   assign loss_cnt   = loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: per-cycle behavioural model comparison plus directed
// scenarios with hand-computed timing expectations.
module tb_pll_reset_seq;

   localparam int unsigned ND  = 4;
   localparam int unsigned ARC = 4;
   localparam int unsigned TO  = 64;
   localparam int unsigned LSC = 8;
   localparam int unsigned STG = 4;
   localparam int unsigned MR  = 3;

   localparam int AR = 0, WL = 1, ST = 2, RL = 3, RN = 4, FL = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          pll_locked = 1'b0;
   logic          soft_rst_req = 1'b0;
   logic          retry_req = 1'b0;
   logic          pll_areset;
   logic [ND-1:0] rst_out;
   logic          ready;
   logic          fail;
   logic [1:0]    retry_cnt;
   logic [7:0]    loss_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   int m_ph = AR, m_age = 0, m_retry = 0, m_loss = 0;
   logic m_sh0 = 1'b0, m_sh1 = 1'b0;
   logic [ND-1:0] m_rst;

   int rel, rise, fall, t0, t3, tr, tl, ta, xr, np, rise_c, fail_at;
   logic prev;

   always #5 clk = ~clk;

   pll_reset_seq #(
      .NUM_DOMAINS   (ND),
      .ARESET_CYCLES (ARC),
      .LOCK_TIMEOUT  (TO),
      .LOCK_STABLE   (LSC),
      .STAGGER       (STG),
      .MAX_RETRY     (MR)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pll_locked   (pll_locked),
      .soft_rst_req (soft_rst_req),
      .retry_req    (retry_req),
      .pll_areset   (pll_areset),
      .rst_out      (rst_out),
      .ready        (ready),
      .fail         (fail),
      .retry_cnt    (retry_cnt),
      .loss_cnt     (loss_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Phase-level model: phase plus number of cycles spent in it
   always @(posedge clk) begin : model
      logic ls;
      int nxt;
      cyc++;
      ls    = m_sh1;
      m_sh1 = m_sh0;
      m_sh0 = pll_locked;
      nxt   = -1;
      if (reset) begin
         m_sh0 = 1'b0; m_sh1 = 1'b0;
         nxt = AR; m_retry = 0; m_loss = 0;
      end else if (soft_rst_req && m_ph != FL) begin
         nxt = AR; m_retry = 0;
      end else begin
         case (m_ph)
            AR: if (m_age == ARC) nxt = WL;
            WL: if (ls) nxt = ST;
                else if (m_age == TO) begin
                   if (m_retry < MR) begin m_retry++; nxt = AR; end
                   else nxt = FL;
                end
            ST: if (!ls) nxt = WL; else if (m_age == LSC) nxt = RL;
            RL: if (!ls) begin
                   if (m_retry < MR) begin m_retry++; nxt = AR; end
                   else nxt = FL;
                end else if (m_age == (ND - 1) * STG + 1) nxt = RN;
            RN: if (!ls) begin
                   if (m_loss < 255) m_loss++;
                   nxt = AR;
                end
            default: if (retry_req) begin m_retry = 0; nxt = AR; end
         endcase
      end
      if (nxt >= 0) begin m_ph = nxt; m_age = 1; end
      else m_age++;
      if (m_ph == RN) m_retry = 0;
      for (int i = 0; i < ND; i++)
         m_rst[i] = (m_ph == RN) ? 1'b0 : (m_ph == RL) ? (m_age <= i * STG) : 1'b1;
      #1;
      chk("model_pll_areset", pll_areset, (m_ph == AR || m_ph == FL));
      chk("model_rst_out", rst_out, m_rst);
      chk("model_ready", ready, (m_ph == RN));
      chk("model_fail", fail, (m_ph == FL));
      chk("model_retry_cnt", retry_cnt, m_retry);
      chk("model_loss_cnt", loss_cnt, m_loss);
   end

   function automatic logic cond(input int w);
      case (w)
         0: return rst_out[0] == 1'b0;
         1: return rst_out[ND-1] == 1'b0;
         2: return ready == 1'b1;
         3: return rst_out == '1;
         4: return fail == 1'b1;
         default: return pll_areset == 1'b1;
      endcase
   endfunction

   task automatic wait_until(input int w, input int limit, input string name, output int at);
      at = -1;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (cond(w)) begin at = cyc; return; end
      end
      n_cmp++; n_bad++;
      $display("FAIL %s: condition not seen within %0d cycles", name, limit);
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      rel = cyc;
   endtask

   task automatic pulse_soft();
      @(negedge clk); soft_rst_req = 1'b1;
      @(negedge clk); soft_rst_req = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pll_areset"}, pll_areset, 1);
      chk({tag, "_rst_out"}, rst_out, 4'hF);
      chk({tag, "_ready"}, ready, 0);
      chk({tag, "_fail"}, fail, 0);
      chk({tag, "_retry_cnt"}, retry_cnt, 0);
      chk({tag, "_loss_cnt"}, loss_cnt, 0);
   endtask

   initial begin
      // reset values
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      reset = 1'b0; rel = cyc;

      // normal bring-up: lock sampled 10 cycles after reset release
      repeat (9) @(negedge clk);
      pll_locked = 1'b1; rise = cyc + 1;
      wait_until(0, 50, "bringup_r0", t0);
      chk("bringup_r0_delay", t0 - rise, LSC + 2);
      wait_until(1, 50, "bringup_r3", t3);
      chk("bringup_r3_delay", t3 - t0, 3 * STG);
      wait_until(2, 50, "bringup_ready", tr);
      chk("bringup_ready_delay", tr - t3, 1);
      chk("bringup_retry", retry_cnt, 0);

      // lock loss in RUN
      repeat (3) @(negedge clk);
      pll_locked = 1'b0; fall = cyc + 1;
      wait_until(3, 10, "runloss_rst", tl);
      chk("runloss_within3", (tl - fall) <= 3, 1);
      chk("runloss_ready", ready, 0);
      chk("runloss_loss_cnt", loss_cnt, 1);
      pll_locked = 1'b1;
      wait_until(2, 100, "runloss_reready", tr);
      chk("runloss_loss_kept", loss_cnt, 1);

      // soft restart keeps loss_cnt; then lock loss during RELEASE counts as a retry
      pulse_soft();
      chk("soft_areset", pll_areset, 1);
      chk("soft_ready", ready, 0);
      chk("soft_loss_kept", loss_cnt, 1);
      wait_until(0, 60, "relloss_enter", t0);
      pll_locked = 1'b0;
      wait_until(5, 10, "relloss_areset", ta);
      chk("relloss_retry", retry_cnt, 1);
      chk("relloss_loss_same", loss_cnt, 1);
      pll_locked = 1'b1;
      wait_until(2, 100, "relloss_reready", tr);
      chk("relloss_retry_cleared", retry_cnt, 0);

      // one-cycle glitch in STABLE delays release, no retry
      pll_locked = 1'b0;
      do_reset();
      repeat (9) @(negedge clk);
      pll_locked = 1'b1; rise = cyc + 1;
      repeat (5) @(negedge clk);
      pll_locked = 1'b0;
      @(negedge clk);
      pll_locked = 1'b1;
      wait_until(0, 60, "glitch_r0", t0);
      chk("glitch_r0_delay", t0 - rise, 16);
      chk("glitch_retry", retry_cnt, 0);

      // lock never arrives: 4 PLL reset pulses then FAIL
      pll_locked = 1'b0;
      do_reset();
      rise_c = rel; np = 0; prev = 1'b1; fail_at = -1;
      for (int k = 0; k < 400 && fail_at < 0; k++) begin
         @(negedge clk);
         if (fail) fail_at = cyc;
         else begin
            if (pll_areset && !prev) begin
               np++; rise_c = cyc;
               chk("timeout_retry_step", retry_cnt, np);
            end
            if (!pll_areset && prev) chk("timeout_pulse_len", cyc - rise_c, ARC);
            prev = pll_areset;
         end
      end
      if (fail_at < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL timeout_fail: fail never asserted");
      end else begin
         chk("timeout_fail_time", fail_at - rel, (MR + 1) * (ARC + TO));
         chk("timeout_retries", np, MR);
         chk("timeout_areset_held", pll_areset, 1);
      end
      pll_locked = 1'b1;
      repeat (20) @(negedge clk);
      chk("fail_ignores_lock", fail, 1);
      pulse_soft();
      chk("fail_ignores_soft", fail, 1);
      chk("fail_rst_out", rst_out, 4'hF);
      pll_locked = 1'b0;
      repeat (3) @(negedge clk);
      @(negedge clk); retry_req = 1'b1;
      @(negedge clk); retry_req = 1'b0; xr = cyc;
      chk("retry_req_retry", retry_cnt, 0);
      chk("retry_req_fail", fail, 0);
      chk("retry_req_areset", pll_areset, 1);

      // soft restart coincides with WAIT_LOCK timeout
      repeat (ARC + TO - 1) @(negedge clk);
      soft_rst_req = 1'b1;
      @(negedge clk);
      soft_rst_req = 1'b0;
      chk("prio_timeout_cyc", cyc - xr, ARC + TO);
      chk("prio_retry", retry_cnt, 0);
      chk("prio_areset", pll_areset, 1);

      // reset while in RUN
      pll_locked = 1'b1;
      wait_until(2, 100, "run_for_reset", tr);
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("reset_in_run");
      reset = 1'b0;

      // loss_cnt saturation over 256 losses
      wait_until(2, 100, "sat_ready", tr);
      for (int i = 1; i <= 256; i++) begin
         pll_locked = 1'b0;
         wait_until(3, 10, "sat_loss", tl);
         pll_locked = 1'b1;
         wait_until(2, 100, "sat_reready", tr);
         if (i == 1)   chk("sat_loss_1", loss_cnt, 1);
         if (i == 254) chk("sat_loss_254", loss_cnt, 254);
      end
      chk("sat_loss_255", loss_cnt, 255);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
